// File: rtl/frame_uart_rx_if.sv
// Receive-side bundle for frame_uart_rx: serial input plus byte/word/pixel/frame outputs.
// The receiver takes the master modport; a consumer or stimulus source takes the slave.
interface frame_uart_rx_if;
    logic        rxd;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [35:0] word_data;
    logic        word_valid;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        frame_done;
    logic        frame_err;

    modport master (
        input  rxd,
        output byte_data, byte_valid, word_data, word_valid,
        output pix_data, pix_valid, frame_done, frame_err
    );

    modport slave (
        output rxd,
        input  byte_data, byte_valid, word_data, word_valid,
        input  pix_data, pix_valid, frame_done, frame_err
    );
endinterface

// File: rtl/frame_uart_rx.sv
// 8N1 receiver that packs 5 bytes into a 36-bit word, unpacks three 12-bit pixels,
// and pulses frame_done after WORDS_PER_FRAME words.
module frame_uart_rx #(
    parameter logic [15:0] DIVISOR         = 16'd1302,
    parameter logic [19:0] WORDS_PER_FRAME = 20'd5,
    parameter logic [19:0] GAP_TIMEOUT     = 20'd500000
) (
    input  logic           CLK,
    input  logic           RST,
    frame_uart_rx_if.master bus
);
    localparam logic [15:0] HALF = DIVISOR >> 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_nxt;

    logic        rx_meta, rxs;
    logic [15:0] tmr;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [2:0]  byte_idx;
    logic [31:0] word_acc;
    logic [19:0] gap_cnt;
    logic [19:0] word_count;
    logic [2:0]  vld_pipe;
    logic        tick, start_det, shift_en, stop_ok, stop_bad;

    assign tick = (tmr == 16'd0);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                start_det = 1'b1;
                state_nxt = START;
            end
            START: if (tick) state_nxt = rxs ? IDLE : DATA;
            DATA: if (tick) begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) state_nxt = STOP;
            end
            STOP: if (tick) begin
                stop_ok   = rxs;
                stop_bad  = !rxs;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta        <= 1'b1;
            rxs            <= 1'b1;
            tmr            <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            byte_idx       <= '0;
            word_acc       <= '0;
            gap_cnt        <= '0;
            word_count     <= '0;
            vld_pipe       <= '0;
            bus.byte_data  <= '0;
            bus.byte_valid <= 1'b0;
            bus.word_data  <= '0;
            bus.word_valid <= 1'b0;
            bus.pix_data   <= '0;
            bus.pix_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            rx_meta <= bus.rxd;
            rxs     <= rx_meta;

            // First sample lands mid start bit, later ones one full bit apart.
            if (start_det)  tmr <= HALF - 16'd1;
            else if (tick)  tmr <= DIVISOR - 16'd1;
            else            tmr <= tmr - 16'd1;

            if (start_det)     bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {rxs, shreg[7:1]};

            bus.byte_valid <= stop_ok;
            if (stop_ok) bus.byte_data <= shreg;

            // Gap timer only runs between bytes of a partially assembled word.
            if (start_det) begin
                gap_cnt <= '0;
            end else if (state == IDLE && byte_idx != 3'd0) begin
                if (gap_cnt >= GAP_TIMEOUT - 20'd1) begin
                    gap_cnt       <= '0;
                    byte_idx      <= '0;
                    bus.frame_err <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + 20'd1;
                end
            end else begin
                gap_cnt <= '0;
            end

            if (stop_bad) begin
                bus.frame_err <= 1'b1;
                byte_idx      <= '0;
            end

            bus.word_valid <= 1'b0;
            if (bus.byte_valid) begin
                if (byte_idx == 3'd4) begin
                    bus.word_data  <= {bus.byte_data[3:0], word_acc};
                    bus.word_valid <= 1'b1;
                    byte_idx       <= '0;
                end else begin
                    word_acc[{byte_idx[1:0], 3'b000} +: 8] <= bus.byte_data;
                    byte_idx <= byte_idx + 3'd1;
                end
            end

            vld_pipe      <= {vld_pipe[1:0], bus.word_valid};
            bus.pix_valid <= bus.word_valid | vld_pipe[0] | vld_pipe[1];
            if (bus.word_valid)   bus.pix_data <= bus.word_data[11:0];
            else if (vld_pipe[0]) bus.pix_data <= bus.word_data[23:12];
            else if (vld_pipe[1]) bus.pix_data <= bus.word_data[35:24];

            bus.frame_done <= 1'b0;
            if (bus.word_valid) word_count <= word_count + 20'd1;
            if (vld_pipe[2] && word_count == WORDS_PER_FRAME) begin
                bus.frame_done <= 1'b1;
                word_count     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_frame_uart_rx.sv
// Randomized scoreboard bench for frame_uart_rx: stimulus pushes expected bytes, words,
// pixels and frame ends into queues; a negedge monitor pops and compares.
module tb_frame_uart_rx;
    localparam int D   = 16;
    localparam int WPF = 2;

    logic CLK, RST;
    frame_uart_rx_if bus();

    frame_uart_rx #(
        .DIVISOR(16'd16), .WORDS_PER_FRAME(20'd2), .GAP_TIMEOUT(20'd200)
    ) dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_bytes[$];
    logic [35:0] exp_words[$];
    logic [11:0] exp_pix[$];
    int          exp_fd[$];
    logic [7:0]  part[$];
    int          wcnt, total_words;
    logic        exp_err;

    int cyc, last_byte_cyc, word_cyc, last_pix_cyc, pix_n, words_seen;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: works on whole bytes and byte groups, not on bit timing.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0]  hi;
        logic [35:0] w;
        exp_bytes.push_back(b);
        part.push_back(b);
        if (part.size() == 5) begin
            hi = part[4];
            w  = {hi[3:0], part[3], part[2], part[1], part[0]};
            part.delete();
            exp_words.push_back(w);
            exp_pix.push_back(w[11:0]);
            exp_pix.push_back(w[23:12]);
            exp_pix.push_back(w[35:24]);
            total_words++;
            wcnt++;
            if (wcnt == WPF) begin
                exp_fd.push_back(total_words);
                wcnt = 0;
            end
        end
    endtask

    task automatic model_reset();
        exp_bytes.delete(); exp_words.delete(); exp_pix.delete(); exp_fd.delete();
        part.delete();
        wcnt = 0; total_words = 0; words_seen = 0; exp_err = 1'b0;
    endtask

    task automatic hold(input logic v, input int n);
        bus.rxd = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good);
        if (good) model_byte(b);
        else begin
            part.delete();
            exp_err = 1'b1;
        end
        hold(1'b0, D);
        for (int i = 0; i < 8; i++) hold(b[i], D);
        // A broken stop bit is kept short so the line is clearly idle again afterwards.
        if (good) hold(1'b1, D);
        else      hold(1'b0, 12);
        bus.rxd = 1'b1;
    endtask

    task automatic send_word(input logic [39:0] bytes, input int max_gap);
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[8*i +: 8], 1'b1);
            repeat ($urandom_range(0, max_gap)) @(negedge CLK);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_byte_data"},  36'(bus.byte_data), 36'd0);
        chk({tag, "_word_data"},  bus.word_data, 36'd0);
        chk({tag, "_pix_data"},   36'(bus.pix_data), 36'd0);
        chk({tag, "_strobes"},    36'({bus.byte_valid, bus.word_valid, bus.pix_valid,
                                       bus.frame_done, bus.frame_err}), 36'd0);
    endtask

    always @(negedge CLK) begin
        logic [35:0] e;
        cyc++;
        if (!RST) begin
            if (bus.byte_valid) begin
                if (exp_bytes.size() == 0) chk("byte_unexpected", 36'(bus.byte_data), 36'hx_dead);
                else begin
                    e = 36'(exp_bytes.pop_front());
                    chk("byte_data", 36'(bus.byte_data), e);
                end
                last_byte_cyc = cyc;
            end
            if (bus.word_valid) begin
                if (exp_words.size() == 0) chk("word_unexpected", bus.word_data, 36'hx_dead);
                else begin
                    e = exp_words.pop_front();
                    chk("word_data", bus.word_data, e);
                end
                chk("word_latency", 36'(cyc), 36'(last_byte_cyc + 1));
                word_cyc = cyc;
                pix_n = 0;
                words_seen++;
            end
            if (bus.pix_valid) begin
                if (exp_pix.size() == 0) chk("pix_unexpected", 36'(bus.pix_data), 36'hx_dead);
                else begin
                    e = 36'(exp_pix.pop_front());
                    chk("pix_data", 36'(bus.pix_data), e);
                end
                chk("pix_latency", 36'(cyc), 36'(word_cyc + 1 + pix_n));
                pix_n++;
                last_pix_cyc = cyc;
            end
            if (bus.frame_done) begin
                if (exp_fd.size() == 0) chk("frame_done_unexpected", 36'(words_seen), 36'hx_dead);
                else begin
                    e = 36'(exp_fd.pop_front());
                    chk("frame_done_word", 36'(words_seen), e);
                end
                chk("frame_done_latency", 36'(cyc), 36'(last_pix_cyc + 1));
            end
        end
    end

    initial begin
        cyc = 0; last_byte_cyc = 0; word_cyc = 0; last_pix_cyc = 0; pix_n = 0;
        model_reset();
        RST = 1'b1;
        bus.rxd = 1'b1;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        RST = 1'b0;
        repeat (10) @(negedge CLK);

        // Known word and its pixel split.
        send_word(40'h09_87_65_43_21, 20);
        repeat (10) @(negedge CLK);
        chk("fixed_word", bus.word_data, 36'h987654321);
        chk("err_after_fixed", 36'(bus.frame_err), 36'(exp_err));

        // Short low glitch must be rejected as a false start.
        hold(1'b0, 4);
        hold(1'b1, 40);
        chk("err_after_glitch", 36'(bus.frame_err), 36'(exp_err));

        // Second word closes the frame; third word starts the next count.
        send_word({$urandom(), 8'($urandom())}, 30);
        send_word({$urandom(), 8'($urandom())}, 30);
        repeat (20) @(negedge CLK);

        // Gap timeout discards a 3-byte partial word.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 1'b1);
        hold(1'b1, 250);
        part.delete();
        exp_err = 1'b1;
        chk("err_after_gap", 36'(bus.frame_err), 36'(exp_err));
        send_word({$urandom(), 8'($urandom())}, 10);
        repeat (20) @(negedge CLK);

        // Reset during the data bits of the fourth byte.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 1'b1);
        hold(1'b0, 3 * D);
        RST = 1'b1;
        @(negedge CLK);
        chk_zero("midreset");
        model_reset();
        bus.rxd = 1'b1;
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        send_word({$urandom(), 8'($urandom())}, 20);
        send_word({$urandom(), 8'($urandom())}, 20);
        repeat (20) @(negedge CLK);
        chk("err_after_reset", 36'(bus.frame_err), 36'(exp_err));

        // Framing error after two good bytes, then a clean word.
        send_byte(8'($urandom()), 1'b1);
        send_byte(8'($urandom()), 1'b1);
        send_byte(8'h5A, 1'b0);
        hold(1'b1, 30);
        chk("err_after_framing", 36'(bus.frame_err), 36'(exp_err));
        send_word({$urandom(), 8'($urandom())}, 20);
        repeat (20) @(negedge CLK);

        // Random traffic with occasional glitches between bytes.
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 5; i++) begin
                send_byte(8'($urandom()), 1'b1);
                if ($urandom_range(0, 5) == 0) begin
                    hold(1'b1, 2);
                    hold(1'b0, $urandom_range(1, 5));
                    hold(1'b1, 20);
                end else begin
                    hold(1'b1, $urandom_range(0, 40));
                end
            end
        end
        repeat (40) @(negedge CLK);

        chk("final_err", 36'(bus.frame_err), 36'(exp_err));
        chk("left_bytes", 36'(exp_bytes.size()), 36'd0);
        chk("left_words", 36'(exp_words.size()), 36'd0);
        chk("left_pix", 36'(exp_pix.size()), 36'd0);
        chk("left_frames", 36'(exp_fd.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
